// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional UART baud enable generator with auto-baud measurement
//
// Purpose:
//   Divides clk by dl_i + dlf_i/2^FRAC_W to produce the oversample enable,
//   emits a bit tick every 2^OS_LOG2 enables, and times the start bit on the
//   receive line to propose a divisor.
//
// Ports:
//   clk          system clock
//   wb_rst_ni    asynchronous active-low reset
//   dl_i         integer divisor
//   dlf_i        fractional divisor (step 1/2^FRAC_W)
//   dl_load_i    restart the divider from dl_i/dlf_i
//   gen_en_i     divider run enable
//   enable_o     oversample enable pulse
//   bit_tick_o   pulse on every 2^OS_LOG2-th enable_o
//   srx_i        synchronised receive line, idle high
//   ab_start_i   start an auto-baud measurement
//   ab_busy_o    measurement in progress
//   ab_done_o    measurement succeeded, ab_dl_o updated
//   ab_err_o     measurement overflowed or rounded to zero
//   ab_dl_o      last successfully measured divisor
module uart_baud_gen_frac #(
    parameter int DL_W     = 16,
    parameter int FRAC_W   = 4,
    parameter int OS_LOG2  = 4,
    parameter int AB_CNT_W = DL_W + OS_LOG2
) (
    input  logic                clk,
    input  logic                wb_rst_ni,
    input  logic [DL_W-1:0]     dl_i,
    input  logic [FRAC_W-1:0]   dlf_i,
    input  logic                dl_load_i,
    input  logic                gen_en_i,
    output logic                enable_o,
    output logic                bit_tick_o,
    input  logic                srx_i,
    input  logic                ab_start_i,
    output logic                ab_busy_o,
    output logic                ab_done_o,
    output logic                ab_err_o,
    output logic [DL_W-1:0]     ab_dl_o
);

    localparam logic [DL_W-1:0]     DL_ONE  = {{(DL_W-1){1'b0}}, 1'b1};
    localparam logic [OS_LOG2-1:0]  OS_ONE  = {{(OS_LOG2-1){1'b0}}, 1'b1};
    localparam logic [OS_LOG2-1:0]  OS_MAX  = {OS_LOG2{1'b1}};
    localparam logic [AB_CNT_W-1:0] AB_ONE  = {{(AB_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AB_CNT_W:0]   AB_HALF = (AB_CNT_W+1)'(2 ** (OS_LOG2 - 1));

    typedef enum logic [1:0] {
        AB_IDLE,
        AB_ARM,
        AB_WAIT_START,
        AB_MEASURE
    } ab_state_t;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [DL_W-1:0]    dlc_q, dlc_d;
    logic [FRAC_W-1:0]  frac_acc_q, frac_acc_d;
    logic [OS_LOG2-1:0] os_cnt_q, os_cnt_d;
    logic               enable_q, enable_d;
    logic               bit_tick_q, bit_tick_d;
    logic [FRAC_W:0]    frac_sum;

    // Carry out of the fraction accumulator stretches the next period by one.
    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, dlf_i};

    always_comb begin
        dlc_d      = dlc_q;
        frac_acc_d = frac_acc_q;
        os_cnt_d   = os_cnt_q;
        enable_d   = 1'b0;
        bit_tick_d = 1'b0;
        if (dl_load_i) begin
            dlc_d      = dl_i - DL_ONE;
            frac_acc_d = '0;
            os_cnt_d   = '0;
        end else if (gen_en_i) begin
            if (dl_i == '0) begin
                dlc_d      = '0;
                frac_acc_d = '0;
            end else if (dlc_q != '0) begin
                dlc_d = dlc_q - DL_ONE;
            end else begin
                frac_acc_d = frac_sum[FRAC_W-1:0];
                dlc_d      = dl_i - DL_ONE + {{(DL_W-1){1'b0}}, frac_sum[FRAC_W]};
                enable_d   = 1'b1;
                os_cnt_d   = os_cnt_q + OS_ONE;
                bit_tick_d = (os_cnt_q == OS_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            dlc_q      <= '0;
            frac_acc_q <= '0;
            os_cnt_q   <= '0;
            enable_q   <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            dlc_q      <= dlc_d;
            frac_acc_q <= frac_acc_d;
            os_cnt_q   <= os_cnt_d;
            enable_q   <= enable_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign enable_o   = enable_q;
    assign bit_tick_o = bit_tick_q;

    // ------------------------------------------------------------------
    // Auto-baud measurement
    // ------------------------------------------------------------------
    ab_state_t           state_q, state_d;
    logic [AB_CNT_W-1:0] ab_cnt_q, ab_cnt_d;
    logic [AB_CNT_W-1:0] ab_cnt_inc;
    logic [DL_W-1:0]     ab_r;
    logic                ab_busy_q, ab_busy_d;
    logic                ab_done_q, ab_done_d;
    logic                ab_err_q, ab_err_d;
    logic [DL_W-1:0]     ab_dl_q, ab_dl_d;

    assign ab_cnt_inc = ab_cnt_q + AB_ONE;
    // Start-bit length in clocks divided by the oversample ratio, rounded to nearest.
    assign ab_r = DL_W'((({1'b0, ab_cnt_q}) + AB_HALF) >> OS_LOG2);

    always_comb begin
        state_d   = state_q;
        ab_cnt_d  = ab_cnt_q;
        ab_busy_d = ab_busy_q;
        ab_done_d = 1'b0;
        ab_err_d  = 1'b0;
        ab_dl_d   = ab_dl_q;
        case (state_q)
            AB_IDLE: begin
                if (ab_start_i) begin
                    state_d   = AB_ARM;
                    ab_busy_d = 1'b1;
                    ab_cnt_d  = '0;
                end
            end
            AB_ARM: begin
                if (srx_i) begin
                    state_d = AB_WAIT_START;
                end
            end
            AB_WAIT_START: begin
                if (!srx_i) begin
                    state_d  = AB_MEASURE;
                    ab_cnt_d = AB_ONE;
                end
            end
            AB_MEASURE: begin
                if (!srx_i) begin
                    ab_cnt_d = ab_cnt_inc;
                    if (ab_cnt_inc == '1) begin
                        ab_err_d  = 1'b1;
                        ab_busy_d = 1'b0;
                        state_d   = AB_IDLE;
                    end
                end else begin
                    if (ab_r == '0) begin
                        ab_err_d = 1'b1;
                    end else begin
                        ab_dl_d   = ab_r;
                        ab_done_d = 1'b1;
                    end
                    ab_busy_d = 1'b0;
                    state_d   = AB_IDLE;
                end
            end
            default: begin
                state_d   = AB_IDLE;
                ab_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= AB_IDLE;
            ab_cnt_q  <= '0;
            ab_busy_q <= 1'b0;
            ab_done_q <= 1'b0;
            ab_err_q  <= 1'b0;
            ab_dl_q   <= '0;
        end else begin
            state_q   <= state_d;
            ab_cnt_q  <= ab_cnt_d;
            ab_busy_q <= ab_busy_d;
            ab_done_q <= ab_done_d;
            ab_err_q  <= ab_err_d;
            ab_dl_q   <= ab_dl_d;
        end
    end

    assign ab_busy_o = ab_busy_q;
    assign ab_done_o = ab_done_q;
    assign ab_err_o  = ab_err_q;
    assign ab_dl_o   = ab_dl_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - self-checking bench for uart_baud_gen_frac
module tb_uart_baud_gen_frac;

    localparam int DL_W     = 16;
    localparam int FRAC_W   = 4;
    localparam int OS_LOG2  = 4;
    localparam int AB_CNT_W = 12;

    logic              clk = 1'b0;
    logic              wb_rst_ni;
    logic [DL_W-1:0]   dl_i;
    logic [FRAC_W-1:0] dlf_i;
    logic              dl_load_i;
    logic              gen_en_i;
    logic              enable_o;
    logic              bit_tick_o;
    logic              srx_i;
    logic              ab_start_i;
    logic              ab_busy_o;
    logic              ab_done_o;
    logic              ab_err_o;
    logic [DL_W-1:0]   ab_dl_o;

    uart_baud_gen_frac #(
        .DL_W(DL_W), .FRAC_W(FRAC_W), .OS_LOG2(OS_LOG2), .AB_CNT_W(AB_CNT_W)
    ) dut (
        .clk(clk), .wb_rst_ni(wb_rst_ni), .dl_i(dl_i), .dlf_i(dlf_i),
        .dl_load_i(dl_load_i), .gen_en_i(gen_en_i), .enable_o(enable_o),
        .bit_tick_o(bit_tick_o), .srx_i(srx_i), .ab_start_i(ab_start_i),
        .ab_busy_o(ab_busy_o), .ab_done_o(ab_done_o), .ab_err_o(ab_err_o),
        .ab_dl_o(ab_dl_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int en_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (enable_o) en_cnt <= en_cnt + 1;

    typedef struct { int t; bit tick; } en_exp_t;
    typedef struct { int dl; int dlf; int n; int last; } div_vec_t;
    typedef struct { int low; bit done; bit err; int dl; } ab_vec_t;

    en_exp_t en_q[$];
    ab_vec_t ab_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (enable_o) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    // k-th enable after a load lands at k*dl + floor((k-1)*dlf/2^FRAC_W).
    task automatic run_div(input div_vec_t v);
        int      l;
        int      tl;
        en_exp_t e;
        dl_i      = v.dl[DL_W-1:0];
        dlf_i     = v.dlf[FRAC_W-1:0];
        gen_en_i  = 1'b1;
        dl_load_i = 1'b1;
        step();
        dl_load_i = 1'b0;
        l  = cyc;
        tl = 0;
        for (int k = 1; k <= v.n; k++) begin
            e.t    = l + k * v.dl + ((k - 1) * v.dlf) / (1 << FRAC_W);
            e.tick = ((k % (1 << OS_LOG2)) == 0);
            en_q.push_back(e);
        end
        for (int c = 0; c < v.n * (v.dl + 2) + 10 && en_q.size() > 0; c++) begin
            @(negedge clk);
            if (enable_o) begin
                e = en_q.pop_front();
                check("en_time", cyc, e.t);
                check("bit_tick", bit_tick_o, e.tick);
                tl = cyc;
            end else if (bit_tick_o) begin
                check("tick_without_enable", bit_tick_o, 0);
            end
        end
        check("en_timeout", en_q.size(), 0);
        en_q.delete();
        check("last_en", tl - l, v.last);
    endtask

    task automatic run_ab(input ab_vec_t v);
        ab_vec_t e;
        bit      seen;
        ab_q.push_back(v);
        srx_i      = 1'b1;
        ab_start_i = 1'b1;
        step();
        ab_start_i = 1'b0;
        step();
        step();
        check("ab_busy_armed", ab_busy_o, 1);
        srx_i = 1'b0;
        repeat (v.low) step();
        check("ab_busy_measure", ab_busy_o, 1);
        srx_i = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ab_done_o || ab_err_o) begin
                seen = 1'b1;
                e = ab_q.pop_front();
                check("ab_done", ab_done_o, e.done);
                check("ab_err", ab_err_o, e.err);
                check("ab_busy_end", ab_busy_o, 0);
                check("ab_dl", ab_dl_o, e.dl);
                @(negedge clk);
                check("ab_pulse_width", ab_done_o | ab_err_o, 0);
                break;
            end
        end
        check("ab_result_seen", seen, 1);
        ab_q.delete();
    endtask

    div_vec_t div_vecs[5];
    ab_vec_t  ab_vecs[8];

    initial begin
        int  t1, t2, t3, t4, e0, c0, f;
        bit  ok, seen, bad;

        div_vecs[0] = '{dl: 4, dlf: 0,  n: 20, last: 80};
        div_vecs[1] = '{dl: 4, dlf: 8,  n: 32, last: 143};
        div_vecs[2] = '{dl: 1, dlf: 0,  n: 20, last: 20};
        div_vecs[3] = '{dl: 7, dlf: 3,  n: 20, last: 143};
        div_vecs[4] = '{dl: 3, dlf: 15, n: 20, last: 77};

        ab_vecs[0] = '{low: 160, done: 1, err: 0, dl: 10};
        ab_vecs[1] = '{low: 167, done: 1, err: 0, dl: 10};
        ab_vecs[2] = '{low: 168, done: 1, err: 0, dl: 11};
        ab_vecs[3] = '{low: 5,   done: 0, err: 1, dl: 11};
        ab_vecs[4] = '{low: 23,  done: 1, err: 0, dl: 1};
        ab_vecs[5] = '{low: 7,   done: 0, err: 1, dl: 1};
        ab_vecs[6] = '{low: 24,  done: 1, err: 0, dl: 2};
        ab_vecs[7] = '{low: 8,   done: 1, err: 0, dl: 1};

        wb_rst_ni  = 1'b0;
        dl_i       = '0;
        dlf_i      = '0;
        dl_load_i  = 1'b0;
        gen_en_i   = 1'b0;
        srx_i      = 1'b1;
        ab_start_i = 1'b0;
        repeat (3) step();
        check("rst_enable", enable_o, 0);
        check("rst_bit_tick", bit_tick_o, 0);
        check("rst_ab_busy", ab_busy_o, 0);
        check("rst_ab_done", ab_done_o, 0);
        check("rst_ab_err", ab_err_o, 0);
        check("rst_ab_dl", ab_dl_o, 0);
        wb_rst_ni = 1'b1;
        repeat (2) step();

        foreach (div_vecs[i]) run_div(div_vecs[i]);

        // Zero divisor: no enables, then a non-zero divisor resumes without a load.
        dl_i      = '0;
        dlf_i     = '0;
        gen_en_i  = 1'b1;
        dl_load_i = 1'b1;
        step();
        dl_load_i = 1'b0;
        repeat (2) step();
        c0 = en_cnt;
        repeat (20) step();
        check("dl0_no_enable", en_cnt - c0, 0);
        e0   = cyc;
        dl_i = 16'd3;
        wait_enable(10, t1, ok);
        check("resume_seen", ok, 1);
        check("resume_latency", t1 - e0, 1);
        wait_enable(10, t2, ok);
        check("resume_period1", t2 - t1, 3);
        wait_enable(10, t3, ok);
        check("resume_period2", t3 - t2, 3);

        // Pause mid-period: the gap stretches by exactly the paused cycles.
        step();
        gen_en_i = 1'b0;
        c0 = en_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("paused_no_enable", en_cnt - c0, 0);
        gen_en_i = 1'b1;
        wait_enable(20, t4, ok);
        check("pause_seen", ok, 1);
        check("pause_period", t4 - t3, 13);

        foreach (ab_vecs[i]) run_ab(ab_vecs[i]);

        // Counter overflow while the line stays low.
        srx_i      = 1'b1;
        ab_start_i = 1'b1;
        step();
        ab_start_i = 1'b0;
        step();
        step();
        srx_i = 1'b0;
        f    = cyc;
        seen = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (ab_done_o || ab_err_o) begin
                seen = 1'b1;
                check("ovf_time", cyc - f, (1 << AB_CNT_W) - 1);
                check("ovf_err", ab_err_o, 1);
                check("ovf_done", ab_done_o, 0);
                check("ovf_busy", ab_busy_o, 0);
                check("ovf_dl_kept", ab_dl_o, 1);
                break;
            end
        end
        check("ovf_seen", seen, 1);
        step();
        srx_i = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ab_done_o || ab_err_o) bad = 1'b1;
        end
        check("ovf_idle_after", bad, 0);
        step();
        ab_start_i = 1'b1;
        step();
        ab_start_i = 1'b0;
        check("ovf_restart_busy", ab_busy_o, 1);

        // Reset in the middle of a measurement and a divider period.
        dl_i      = 16'd4;
        dl_load_i = 1'b1;
        step();
        dl_load_i = 1'b0;
        step();
        srx_i = 1'b0;
        repeat (50) step();
        wb_rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", ab_busy_o, 0);
        check("mid_rst_enable", enable_o, 0);
        check("mid_rst_dl", ab_dl_o, 0);
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (enable_o || bit_tick_o || ab_done_o || ab_err_o || ab_busy_o) bad = 1'b1;
        end
        check("in_rst_quiet", bad, 0);
        srx_i    = 1'b1;
        gen_en_i = 1'b0;
        step();
        wb_rst_ni = 1'b1;
        bad = 1'b0;
        c0  = en_cnt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ab_done_o || ab_err_o || ab_busy_o) bad = 1'b1;
        end
        check("post_rst_ab_quiet", bad, 0);
        check("post_rst_div_idle", en_cnt - c0, 0);
        step();
        e0       = cyc;
        gen_en_i = 1'b1;
        wait_enable(10, t1, ok);
        check("post_rst_reload_seen", ok, 1);
        check("post_rst_reload_latency", t1 - e0, 1);
        run_ab('{low: 160, done: 1, err: 0, dl: 10});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
